// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: default widths, ALU opcodes and
// the operand forward-select encoding.
package id_ex_stage_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int OP_WIDTH_DEF       = 4;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int SHAMT_WIDTH        = 5;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_NOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// One operand's bypass: EX/MEM beats MEM/WB beats register file; $zero is
// never bypassed.
module forward_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_dest,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_dest,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (exmem_reg_write && exmem_dest != '0 && exmem_dest == src_addr)
      sel = FWD_EXMEM;
    else if (memwb_reg_write && memwb_dest != '0 && memwb_dest == src_addr)
      sel = FWD_MEMWB;
  end

  always_comb begin
    fwd_data = rf_data;
    case (sel)
      FWD_EXMEM: fwd_data = exmem_result;
      FWD_MEMWB: fwd_data = memwb_result;
      default:   fwd_data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with stall/flush and rs/rt
// forwarding applied on the registered operands.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int OP_WIDTH       = OP_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [OP_WIDTH-1:0]       in_alu_op,
  input  logic [DATA_WIDTH-1:0]     in_rs_data,
  input  logic [DATA_WIDTH-1:0]     in_rt_data,
  input  logic [DATA_WIDTH-1:0]     in_imm_ext,
  input  logic                      in_alu_src,
  input  logic [SHAMT_WIDTH-1:0]    in_shamt,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rt_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_dest_addr,
  input  logic                      in_reg_write,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_dest,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_dest,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [OP_WIDTH-1:0]       ALUOperation,
  output logic [DATA_WIDTH-1:0]     A,
  output logic [DATA_WIDTH-1:0]     B,
  output logic [SHAMT_WIDTH-1:0]    shamt,
  output logic [DATA_WIDTH-1:0]     store_data,
  output logic                      out_valid,
  output logic [REG_ADDR_WIDTH-1:0] out_dest_addr,
  output logic                      out_reg_write
);

  logic                      valid_q, alu_src_q, reg_write_q;
  logic [OP_WIDTH-1:0]       op_q;
  logic [DATA_WIDTH-1:0]     rs_data_q, rt_data_q, imm_q;
  logic [SHAMT_WIDTH-1:0]    shamt_q;
  logic [REG_ADDR_WIDTH-1:0] rs_addr_q, rt_addr_q, dest_q;

  // A flush zeroes the stage, which yields a bubble with ALUOperation=AND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      valid_q     <= 1'b0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      op_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      dest_q      <= '0;
    end else if (!stall) begin
      valid_q     <= in_valid;
      alu_src_q   <= in_alu_src;
      reg_write_q <= in_reg_write & in_valid;
      op_q        <= in_alu_op;
      rs_data_q   <= in_rs_data;
      rt_data_q   <= in_rt_data;
      imm_q       <= in_imm_ext;
      shamt_q     <= in_shamt;
      rs_addr_q   <= in_rs_addr;
      rt_addr_q   <= in_rt_addr;
      dest_q      <= in_dest_addr;
    end
  end

  // Operand 0 is rs, operand 1 is rt.
  logic [1:0][REG_ADDR_WIDTH-1:0] src_addr;
  logic [1:0][DATA_WIDTH-1:0]     rf_data;
  logic [1:0][DATA_WIDTH-1:0]     fwd_data;

  assign src_addr = {rt_addr_q, rs_addr_q};
  assign rf_data  = {rt_data_q, rs_data_q};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    forward_mux #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd (
      .src_addr        (src_addr[i]),
      .rf_data         (rf_data[i]),
      .exmem_reg_write (exmem_reg_write),
      .exmem_dest      (exmem_dest),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_dest      (memwb_dest),
      .memwb_result    (memwb_result),
      .fwd_data        (fwd_data[i])
    );
  end

  assign A             = fwd_data[0];
  assign store_data    = fwd_data[1];
  assign B             = alu_src_q ? imm_q : fwd_data[1];
  assign ALUOperation  = op_q;
  assign shamt         = shamt_q;
  assign out_valid     = valid_q;
  assign out_dest_addr = dest_q;
  assign out_reg_write = reg_write_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the 32-bit ALU.
- Captures decoded operands and control from the decode stage once per cycle.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Drives ALUOperation, A, B and shamt straight into the ALU. Supports stall (hold) and flush (bubble insertion).

Parameters:
- DATA_WIDTH, 32, operand/result width
- OP_WIDTH, 4, ALU operation code width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- stall  input  1  hold all stage registers this cycle
- flush  input  1  load a bubble this cycle
- in_valid  input  1  decode stage holds a real instruction
- in_alu_op  input  OP_WIDTH  ALU operation code from the ALU control decoder
- in_rs_data  input  DATA_WIDTH  register-file read port 1
- in_rt_data  input  DATA_WIDTH  register-file read port 2
- in_imm_ext  input  DATA_WIDTH  sign/zero-extended immediate
- in_alu_src  input  1  1 = B takes the immediate, 0 = B takes rt
- in_shamt  input  5  shift amount field
- in_rs_addr, in_rt_addr  input  REG_ADDR_WIDTH  source register indices
- in_dest_addr  input  REG_ADDR_WIDTH  destination register index
- in_reg_write  input  1  instruction writes the register file
- exmem_reg_write  input  1  EX/MEM stage will write a register
- exmem_dest  input  REG_ADDR_WIDTH  EX/MEM destination index
- exmem_result  input  DATA_WIDTH  EX/MEM ALU result
- memwb_reg_write  input  1  MEM/WB stage will write a register
- memwb_dest  input  REG_ADDR_WIDTH  MEM/WB destination index
- memwb_result  input  DATA_WIDTH  MEM/WB writeback value
- ALUOperation  output  OP_WIDTH  to ALU
- A  output  DATA_WIDTH  to ALU
- B  output  DATA_WIDTH  to ALU
- shamt  output  5  to ALU
- store_data  output  DATA_WIDTH  forwarded rt, for stores
- out_valid  output  1  stage holds a real instruction
- out_dest_addr  output  REG_ADDR_WIDTH  destination passed downstream
- out_reg_write  output  1  in_reg_write gated by valid

Behaviour:
- Reset (reset=0, asynchronous): every stage register clears to 0.
  - Result: out_valid=0, out_reg_write=0, ALUOperation=4'b0000 (AND), shamt=0, out_dest_addr=0.
  - A, B and store_data equal the forwarding result on zeroed registers.
- Reset released mid-stream: the first capture happens on the first rising clk edge with reset=1.
- Each rising edge applies exactly one of the following, in priority order:
  1. flush=1: load a bubble. All registers go to 0, so out_valid=0 and out_reg_write=0. Flush wins over a simultaneous stall.
  2. stall=1: every register holds its value.
  3. Otherwise: capture all in_* fields. Latency is 1 cycle from decode to ALU inputs. The captured reg_write is in_reg_write AND in_valid.
- Forwarding is combinational on the registered fields, resolved independently for the rs and rt operands:
  - EX/MEM match = exmem_reg_write && exmem_dest != 0 && exmem_dest == captured source index → use exmem_result.
  - Else MEM/WB match (same rule with memwb_*) → use memwb_result.
  - Else use the captured register-file data.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never forwarded.
- Output mapping:
  - A = forwarded rs.
  - store_data = forwarded rt.
  - B = captured alu_src ? captured imm : forwarded rt.
  - ALUOperation and shamt come straight from registers. No operand width changes; all paths are DATA_WIDTH.
- Forwarding is not gated by out_valid. Bubbles are harmless because out_reg_write=0.
- Load-use hazards are the hazard unit's job (it drives stall/flush). This block never stalls itself.

Decomposition:
- Shared package/include holds:
  - ALU opcode constants: AND=0, OR=1, NOR=2, ADD=3, SUB=4, SLL=5, SRL=6, LUI=7.
  - DATA_WIDTH, OP_WIDTH, REG_ADDR_WIDTH defaults.
  - Forward-select encoding: 2'b00 regfile, 2'b01 MEM/WB, 2'b10 EX/MEM.
- One sub-module, forward_mux: a combinational priority compare plus a 3:1 mux, instantiated twice (rs, rt).

Test Plan:
1. Hold reset=0 with random inputs → out_valid=0, ALUOperation=0, out_reg_write=0. Release reset, drive valid ADD (op=3, rs_data=5, rt_data=7, alu_src=0) → after one edge A=5, B=7, ALUOperation=3, out_valid=1.
2. Capture op=SUB, then assert stall for 3 cycles while the inputs change → outputs stay SUB/5/7. Deassert stall → the new values appear after one edge.
3. Assert stall=1 and flush=1 together → out_valid=0, out_reg_write=0, ALUOperation=0 on the next edge.
4. Captured rs_addr=8, exmem(reg_write=1, dest=8, result=0xAAAA0000), memwb(reg_write=1, dest=8, result=0x12345678) → A=0xAAAA0000. Drop exmem_reg_write → A=0x12345678.
5. Captured rt_addr=0, exmem_dest=0, exmem_reg_write=1, exmem_result=0xFFFFFFFF, rt_data=0 → B=0 and store_data=0 (no forward from $zero).
6. Drive alu_src=1, imm=0x0000FFFF, rt forwarded to 0xDEAD0000, op=LUI → B=0x0000FFFF, store_data=0xDEAD0000.
